// File: rtl/sysbus_arbiter_pkg.sv
// sysbus_arbiter_pkg
// Shared system-bus types and constants used by the bus interface, the
// system-bus arbiter and its bench.
//   ttype_e             : transaction direction (READ/WRITE)
//   tsize_e             : access size (BYTE/HALF/WORD)
//   arb_state_e         : arbiter FSM state (IDLE/START/WAIT)
//   SYSBUS_TIMEOUT_DATA : read data returned on a forced completion
package sysbus_arbiter_pkg;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } ttype_e;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2,
      RSVD = 2'd3
   } tsize_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   localparam logic [31:0] SYSBUS_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/sysbus_arbiter_if.sv
// sysbus_arbiter_if
// One system-bus channel: request side (breq, bstart, ttype, tsize, addr,
// wdata) and response side (rdata, bdone).
//   modport master : the side that issues transactions
//   modport slave  : the side that serves them
//
// Handshake: a transaction starts with a one-cycle bstart pulse (breq pulses
// with it). addr/wdata/ttype/tsize stay stable from bstart until the cycle
// bdone is high. bdone is a one-cycle completion pulse; rdata is valid in that
// same cycle. Only one transaction per channel may be outstanding.
interface sysbus_arbiter_if;
   import sysbus_arbiter_pkg::*;

   logic        breq;
   logic        bstart;
   ttype_e      ttype;
   tsize_e      tsize;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        bdone;

   modport master (
      output breq, bstart, ttype, tsize, addr, wdata,
      input  rdata, bdone
   );

   modport slave (
      input  breq, bstart, ttype, tsize, addr, wdata,
      output rdata, bdone
   );

endinterface

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
// Shares the single system-bus slave port between the core data port (m0)
// and the debug module system-bus access (m1). Round-robin arbitration with
// a debug-priority override; one slave transaction in flight at a time.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   m0, m1     : master channels (slave modport of sysbus_arbiter_if)
//   s          : channel to the interconnect (master modport)
//   dbg_prio   : when high, m1 wins every arbitration
//   owner      : current/last granted master
//   busy       : slave transaction in flight
//   timeout    : forced-completion pulse
//   state_dbg  : FSM state, for observation
//   pend_dbg   : pending request bits {pend1, pend0}, for observation
//
// Optional build macro SYSBUS_ARB_TIMEOUT_EN: when defined, a transaction
// still waiting after TIMEOUT_CYCLES WAIT cycles is completed locally with
// SYSBUS_TIMEOUT_DATA and a timeout pulse. When undefined, WAIT never ends
// without s.bdone and timeout is tied low.
module sysbus_arbiter
   import sysbus_arbiter_pkg::*;
#(
   parameter logic RR_INIT        = 1'b0,
   parameter int   TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   sysbus_arbiter_if.slave  m0,
   sysbus_arbiter_if.slave  m1,
   sysbus_arbiter_if.master s,
   input  logic             dbg_prio,
   output logic             owner,
   output logic             busy,
   output logic             timeout,
   output arb_state_e       state_dbg,
   output logic [1:0]       pend_dbg
);

   arb_state_e  state_q, state_d;
   logic [1:0]  pend_q, pend_d;
   logic        rr_q, rr_d;
   logic        owner_q, owner_d;
   logic        in_flight;
   logic [1:0]  start_raw, start_ok, req;
   logic        winner;
   logic        done;
   logic        to_hit;
   logic [31:0] resp_data;

   // Both requesting: dbg_prio forces m1, otherwise the round-robin pointer
   // decides. One requesting: that one wins (req[1] is then the answer).
   function automatic logic pick_winner(input logic [1:0] cand,
                                        input logic       prio,
                                        input logic       rr);
      if (cand == 2'b11) begin
         return prio ? 1'b1 : rr;
      end
      return cand[1];
   endfunction

   assign in_flight = (state_q != IDLE);
   assign start_raw = {m1.bstart, m0.bstart};

   // A start while already pending, or from the master whose transaction is
   // still in flight, is a protocol violation and is dropped.
   assign start_ok[0] = start_raw[0] & ~pend_q[0] & ~(in_flight & ~owner_q);
   assign start_ok[1] = start_raw[1] & ~pend_q[1] & ~(in_flight &  owner_q);

   // Same-cycle starts are eligible immediately.
   assign req    = pend_q | start_ok;
   assign winner = pick_winner(req, dbg_prio, rr_q);

`ifdef SYSBUS_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_q;

   // Counts completed WAIT cycles; the 16th WAIT cycle sees count 15 when
   // TIMEOUT_CYCLES is 16, so compare against TIMEOUT_CYCLES-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (state_q == START) begin
         to_cnt_q <= '0;
      end else if (state_q == WAIT) begin
         to_cnt_q <= to_cnt_q + 16'd1;
      end
   end

   assign to_hit = (state_q == WAIT) && !s.bdone &&
                   (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= 2'b00;
         rr_q    <= RR_INIT;
         owner_q <= RR_INIT;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q | start_ok;
      rr_d     = rr_q;
      owner_d  = owner_q;
      s.breq   = 1'b0;
      s.bstart = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d        = winner;
               rr_d           = ~winner;
               pend_d[winner] = 1'b0;
               state_d        = START;
            end
         end
         START: begin
            s.breq   = 1'b1;
            s.bstart = 1'b1;
            busy     = 1'b1;
            if (s.bdone) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (s.bdone) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (to_hit) begin
               done    = 1'b1;
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request fields follow the owner; they are meaningful in START and WAIT.
   assign s.ttype = owner_q ? m1.ttype : m0.ttype;
   assign s.tsize = owner_q ? m1.tsize : m0.tsize;
   assign s.addr  = owner_q ? m1.addr  : m0.addr;
   assign s.wdata = owner_q ? m1.wdata : m0.wdata;

   assign resp_data = timeout ? SYSBUS_TIMEOUT_DATA : s.rdata;
   assign m0.rdata  = owner_q ? 32'h0 : resp_data;
   assign m1.rdata  = owner_q ? resp_data : 32'h0;
   assign m0.bdone  = done & ~owner_q;
   assign m1.bdone  = done &  owner_q;

   assign owner     = owner_q;
   assign state_dbg = state_q;
   assign pend_dbg  = pend_q;

`ifndef SYNTHESIS
   a_m0_proto: assert property (@(posedge clk) disable iff (rst)
      m0.bstart |-> !(pend_q[0] || (in_flight && !owner_q)));
   a_m1_proto: assert property (@(posedge clk) disable iff (rst)
      m1.bstart |-> !(pend_q[1] || (in_flight && owner_q)));
   a_m0_breq: assert property (@(posedge clk) disable iff (rst)
      m0.breq == m0.bstart);
   a_m1_breq: assert property (@(posedge clk) disable iff (rst)
      m1.breq == m1.bstart);
   a_timeout_range: assert property (@(posedge clk)
      (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535));
`endif

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter
// Bench for sysbus_arbiter (RR_INIT=0, TIMEOUT_CYCLES=16). Directed scenarios
// followed by randomized traffic checked against a transaction-schedule model.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_sysbus_arbiter;
   import sysbus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dbg_prio = 1'b0;
   logic       owner, busy, timeout;
   arb_state_e state_dbg;
   logic [1:0] pend_dbg;

   int total = 0;
   int bad   = 0;

   sysbus_arbiter_if m0_if ();
   sysbus_arbiter_if m1_if ();
   sysbus_arbiter_if s_if ();

   sysbus_arbiter #(
      .RR_INIT        (1'b0),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .s         (s_if),
      .dbg_prio  (dbg_prio),
      .owner     (owner),
      .busy      (busy),
      .timeout   (timeout),
      .state_dbg (state_dbg),
      .pend_dbg  (pend_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic idle_pulses();
      m0_if.breq   = 1'b0;
      m0_if.bstart = 1'b0;
      m1_if.breq   = 1'b0;
      m1_if.bstart = 1'b0;
      s_if.bdone   = 1'b0;
   endtask

   task automatic init_inputs();
      idle_pulses();
      m0_if.ttype = READ;  m0_if.tsize = WORD; m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
      m1_if.ttype = READ;  m1_if.tsize = WORD; m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
      s_if.rdata  = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      dbg_prio = 1'b0;
      idle_pulses();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic m0_issue(input ttype_e tt, input logic [31:0] a, input logic [31:0] wd);
      m0_if.breq = 1'b1; m0_if.bstart = 1'b1;
      m0_if.ttype = tt; m0_if.tsize = WORD; m0_if.addr = a; m0_if.wdata = wd;
   endtask

   task automatic m1_issue(input ttype_e tt, input logic [31:0] a, input logic [31:0] wd);
      m1_if.breq = 1'b1; m1_if.bstart = 1'b1;
      m1_if.ttype = tt; m1_if.tsize = WORD; m1_if.addr = a; m1_if.wdata = wd;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_pulses();
      m0_issue(READ, 32'h4, 32'h0);  // start during reset must be discarded
      @(negedge clk);
      idle_pulses();
      #1;
      total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
      total++; if (pend_dbg !== 2'b00) begin bad++; $display("FAIL reset_pend got=%b exp=00", pend_dbg); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
      total++; if ({s_if.bstart, s_if.breq, m0_if.bdone, m1_if.bdone} !== 4'b0000) begin
         bad++; $display("FAIL reset_pulses got=%b exp=0000", {s_if.bstart, s_if.breq, m0_if.bdone, m1_if.bdone});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      total++; if (s_if.bstart !== 1'b0 || state_dbg !== IDLE) begin
         bad++; $display("FAIL reset_no_grant got bstart=%b state=%0d exp bstart=0 state=0", s_if.bstart, state_dbg);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         idle_pulses();
         if (c == 0) m0_issue(READ, 32'h8000_0000, 32'h0);
         if (c == 4) begin s_if.bdone = 1'b1; s_if.rdata = 32'h1234_5678; end
         #1;
         total++; if (s_if.bstart !== (c == 1)) begin bad++; $display("FAIL rd_sbstart c=%0d got=%b exp=%b", c, s_if.bstart, c == 1); end
         total++; if (busy !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL rd_busy c=%0d got=%b exp=%b", c, busy, c >= 1 && c <= 4); end
         total++; if (m0_if.bdone !== (c == 4)) begin bad++; $display("FAIL rd_m0_bdone c=%0d got=%b exp=%b", c, m0_if.bdone, c == 4); end
         total++; if (m1_if.bdone !== 1'b0) begin bad++; $display("FAIL rd_m1_bdone c=%0d got=%b exp=0", c, m1_if.bdone); end
         if (c == 1) begin
            total++; if (s_if.addr !== 32'h8000_0000 || s_if.ttype !== READ || s_if.breq !== 1'b1) begin
               bad++; $display("FAIL rd_fwd got addr=%h tt=%0d breq=%b exp addr=80000000 tt=0 breq=1", s_if.addr, s_if.ttype, s_if.breq);
            end
         end
         if (c == 4) begin
            total++; if (m0_if.rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_m0_rdata got=%h exp=12345678", m0_if.rdata); end
            total++; if (m1_if.rdata !== 32'h0) begin bad++; $display("FAIL rd_m1_rdata got=%h exp=00000000", m1_if.rdata); end
         end
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         idle_pulses();
         if (c == 0) begin
            m0_issue(READ, 32'h0000_1000, 32'h0);
            m1_issue(READ, 32'h0000_2000, 32'h0);
         end
         if (c == 2 || c == 4) begin s_if.bdone = 1'b1; s_if.rdata = 32'hA0 + 32'(c); end
         #1;
         total++; if (s_if.bstart !== (c == 1 || c == 4)) begin bad++; $display("FAIL sc_sbstart c=%0d got=%b exp=%b", c, s_if.bstart, c == 1 || c == 4); end
         total++; if (m0_if.bdone !== (c == 2)) begin bad++; $display("FAIL sc_m0_bdone c=%0d got=%b exp=%b", c, m0_if.bdone, c == 2); end
         total++; if (m1_if.bdone !== (c == 4)) begin bad++; $display("FAIL sc_m1_bdone c=%0d got=%b exp=%b", c, m1_if.bdone, c == 4); end
         if (c == 1) begin
            total++; if (owner !== 1'b0 || s_if.addr !== 32'h0000_1000) begin bad++; $display("FAIL sc_first got owner=%b addr=%h exp owner=0 addr=00001000", owner, s_if.addr); end
         end
         if (c == 3) begin
            total++; if (pend_dbg !== 2'b10 || busy !== 1'b0) begin bad++; $display("FAIL sc_gap got pend=%b busy=%b exp pend=10 busy=0", pend_dbg, busy); end
         end
         if (c == 4) begin
            total++; if (owner !== 1'b1 || s_if.addr !== 32'h0000_2000) begin bad++; $display("FAIL sc_second got owner=%b addr=%h exp owner=1 addr=00002000", owner, s_if.addr); end
         end
      end
   endtask

   task automatic run_continuous(input logic prio);
      logic [0:0] exp_q[$];
      logic [0:0] exp_own;
      logic       out0, out1;
      int         seen, done_at;
      for (int i = 0; i < 6; i++) exp_q.push_back(prio ? 1'b1 : 1'(i % 2));
      do_reset();
      dbg_prio = prio;
      out0 = 1'b0; out1 = 1'b0; seen = 0; done_at = -1;
      for (int cyc = 0; cyc < 100 && seen < 6; cyc++) begin
         @(negedge clk);
         idle_pulses();
         if (!out0) begin m0_issue(READ, 32'h0000_0100 | 32'(cyc), 32'h0); out0 = 1'b1; end
         if (!out1) begin m1_issue(READ, 32'h0000_0200 | 32'(cyc), 32'h0); out1 = 1'b1; end
         if (cyc == done_at) begin s_if.bdone = 1'b1; s_if.rdata = 32'(cyc); end
         #1;
         if (s_if.bstart) begin
            exp_own = exp_q.pop_front();
            total++;
            if (owner !== exp_own || s_if.addr[11:8] !== (exp_own ? 4'h2 : 4'h1)) begin
               bad++; $display("FAIL fair_prio%0d grant%0d got owner=%b addr=%h exp owner=%b", prio, seen, owner, s_if.addr, exp_own);
            end
            seen++;
            done_at = cyc + int'($urandom_range(1, 3));
         end
         if (m0_if.bdone) out0 = 1'b0;
         if (m1_if.bdone) out1 = 1'b0;
      end
      total++;
      if (seen != 6) begin bad++; $display("FAIL fair_prio%0d_budget got grants=%0d exp=6", prio, seen); end
      dbg_prio = 1'b0;
   endtask

   task automatic test_fairness();
      run_continuous(1'b0);
      run_continuous(1'b1);
   endtask

   task automatic test_write_during_wait();
      do_reset();
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         idle_pulses();
         if (c == 0) m0_issue(READ, 32'h0000_3000, 32'h0);
         if (c == 2) m1_issue(WRITE, 32'h1000_0004, 32'hCAFE_F00D);
         if (c == 4 || c == 7) begin s_if.bdone = 1'b1; s_if.rdata = 32'h55; end
         #1;
         total++; if (s_if.bstart !== (c == 1 || c == 6)) begin bad++; $display("FAIL wr_sbstart c=%0d got=%b exp=%b", c, s_if.bstart, c == 1 || c == 6); end
         if (c == 3) begin
            total++; if (pend_dbg !== 2'b10 || s_if.addr !== 32'h0000_3000) begin bad++; $display("FAIL wr_hold got pend=%b addr=%h exp pend=10 addr=00003000", pend_dbg, s_if.addr); end
         end
         if (c == 4) begin
            total++; if (m0_if.bdone !== 1'b1 || m1_if.bdone !== 1'b0) begin bad++; $display("FAIL wr_m0_done got m0=%b m1=%b exp m0=1 m1=0", m0_if.bdone, m1_if.bdone); end
         end
         if (c == 6) begin
            total++; if (s_if.wdata !== 32'hCAFE_F00D || s_if.ttype !== WRITE || s_if.addr !== 32'h1000_0004 || owner !== 1'b1) begin
               bad++; $display("FAIL wr_fwd got wdata=%h tt=%0d addr=%h owner=%b exp wdata=cafef00d tt=1 addr=10000004 owner=1", s_if.wdata, s_if.ttype, s_if.addr, owner);
            end
         end
         if (c == 7) begin
            total++; if (m1_if.bdone !== 1'b1 || m0_if.bdone !== 1'b0) begin bad++; $display("FAIL wr_m1_done got m1=%b m0=%b exp m1=1 m0=0", m1_if.bdone, m0_if.bdone); end
         end
      end
   endtask

   task automatic test_done_collision();
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         idle_pulses();
         if (c == 0) m0_issue(READ, 32'h0000_4000, 32'h0);
         if (c == 2) begin s_if.bdone = 1'b1; s_if.rdata = 32'h77; m1_issue(READ, 32'h0000_5000, 32'h0); end
         #1;
         if (c == 2) begin
            total++; if (m0_if.bdone !== 1'b1 || m0_if.rdata !== 32'h77) begin bad++; $display("FAIL col_done got bdone=%b rdata=%h exp bdone=1 rdata=00000077", m0_if.bdone, m0_if.rdata); end
         end
         if (c == 3) begin
            total++; if (pend_dbg !== 2'b10 || s_if.bstart !== 1'b0) begin bad++; $display("FAIL col_pend got pend=%b sbstart=%b exp pend=10 sbstart=0", pend_dbg, s_if.bstart); end
         end
         if (c == 4) begin
            total++; if (s_if.bstart !== 1'b1 || owner !== 1'b1 || s_if.addr !== 32'h0000_5000) begin
               bad++; $display("FAIL col_grant got sbstart=%b owner=%b addr=%h exp 1 1 00005000", s_if.bstart, owner, s_if.addr);
            end
         end
      end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         idle_pulses();
         rst = (c == 3);
         if (c == 0) m0_issue(READ, 32'h0000_6000, 32'h0);
         if (c == 2) m1_issue(READ, 32'h0000_7000, 32'h0);
         if (c == 4) begin s_if.bdone = 1'b1; s_if.rdata = 32'h99; end
         #1;
         if (c == 4) begin
            total++; if (busy !== 1'b0 || pend_dbg !== 2'b00 || state_dbg !== IDLE) begin
               bad++; $display("FAIL rw_cleared got busy=%b pend=%b state=%0d exp 0 00 0", busy, pend_dbg, state_dbg);
            end
            total++; if (m0_if.bdone !== 1'b0 || m1_if.bdone !== 1'b0) begin bad++; $display("FAIL rw_late_done got m0=%b m1=%b exp 0 0", m0_if.bdone, m1_if.bdone); end
         end
         if (c == 5) begin
            total++; if (s_if.bstart !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rw_no_restart got sbstart=%b busy=%b exp 0 0", s_if.bstart, busy); end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
`ifdef SYSBUS_ARB_TIMEOUT_EN
      for (int k = 0; k <= 19; k++) begin
         @(negedge clk);
         idle_pulses();
         if (k == 0) m0_issue(READ, 32'h0000_8000, 32'h0);
         if (k == 18) s_if.bdone = 1'b1;  // late response, must be ignored
         #1;
         total++; if (m0_if.bdone !== (k == 17)) begin bad++; $display("FAIL to_bdone k=%0d got=%b exp=%b", k, m0_if.bdone, k == 17); end
         total++; if (timeout !== (k == 17)) begin bad++; $display("FAIL to_pulse k=%0d got=%b exp=%b", k, timeout, k == 17); end
         if (k == 17) begin
            total++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_rdata got=%h exp=deadbeef", m0_if.rdata); end
         end
      end
`else
      for (int k = 0; k <= 41; k++) begin
         @(negedge clk);
         idle_pulses();
         if (k == 0) m0_issue(READ, 32'h0000_8000, 32'h0);
         if (k == 41) begin s_if.bdone = 1'b1; s_if.rdata = 32'h1357_9BDF; end
         #1;
         total++; if (timeout !== 1'b0) begin bad++; $display("FAIL nto_pulse k=%0d got=%b exp=0", k, timeout); end
         total++; if (m0_if.bdone !== (k == 41)) begin bad++; $display("FAIL nto_bdone k=%0d got=%b exp=%b", k, m0_if.bdone, k == 41); end
         if (k >= 1) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL nto_busy k=%0d got=%b exp=1", k, busy); end
         end
      end
`endif
   endtask

   // Randomized traffic against a schedule model: requests wait in per-master
   // slots, a grant is decided on any cycle the slave is free and at least one
   // cycle has passed since the last completion, and the granted request
   // appears on the slave port the cycle after the decision.
   task automatic test_random();
      logic        wait_v[2];
      ttype_e      w_tt[2];
      tsize_e      w_ts[2];
      logic [31:0] w_addr[2], w_wdata[2];
      logic        outst[2];
      logic        issued;
      logic        serving, srv_own, own_exp, pref, exp_done, exp_sb;
      ttype_e      c_tt;
      tsize_e      c_ts;
      logic [31:0] c_addr, c_wdata, rd;
      int          start_cyc, done_cyc, ready_cyc, w;
      do_reset();
      for (int x = 0; x < 2; x++) begin wait_v[x] = 1'b0; outst[x] = 1'b0; end
      serving = 1'b0; srv_own = 1'b0; own_exp = 1'b0; pref = 1'b0;
      start_cyc = -1; done_cyc = -1; ready_cyc = 0;
      c_tt = READ; c_ts = WORD; c_addr = 0; c_wdata = 0; rd = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         idle_pulses();
         if ($urandom_range(0, 7) == 0) dbg_prio = ~dbg_prio;
         for (int x = 0; x < 2; x++) begin
            issued = !outst[x] && ($urandom_range(0, 2) == 0);
            if (issued) begin
               outst[x]   = 1'b1;
               wait_v[x]  = 1'b1;
               w_tt[x]    = ttype_e'($urandom_range(0, 1));
               w_ts[x]    = tsize_e'($urandom_range(0, 2));
               w_addr[x]  = $urandom;
               w_wdata[x] = $urandom;
               if (x == 0) begin
                  m0_if.breq = 1'b1; m0_if.bstart = 1'b1; m0_if.ttype = w_tt[0];
                  m0_if.tsize = w_ts[0]; m0_if.addr = w_addr[0]; m0_if.wdata = w_wdata[0];
               end else begin
                  m1_if.breq = 1'b1; m1_if.bstart = 1'b1; m1_if.ttype = w_tt[1];
                  m1_if.tsize = w_ts[1]; m1_if.addr = w_addr[1]; m1_if.wdata = w_wdata[1];
               end
            end
         end
         exp_sb   = serving && (t == start_cyc);
         exp_done = serving && (t == done_cyc);
         rd = $urandom;
         s_if.rdata = rd;
         s_if.bdone = exp_done;
         #1;
         total++; if (s_if.bstart !== exp_sb) begin bad++; $display("FAIL rnd_sbstart t=%0d got=%b exp=%b", t, s_if.bstart, exp_sb); end
         total++; if (owner !== own_exp) begin bad++; $display("FAIL rnd_owner t=%0d got=%b exp=%b", t, owner, own_exp); end
         total++; if (busy !== (serving && t >= start_cyc)) begin bad++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, busy, serving && t >= start_cyc); end
         total++; if (m0_if.bdone !== (exp_done && !srv_own) || m1_if.bdone !== (exp_done && srv_own)) begin
            bad++; $display("FAIL rnd_bdone t=%0d got m0=%b m1=%b exp m0=%b m1=%b", t, m0_if.bdone, m1_if.bdone, exp_done && !srv_own, exp_done && srv_own);
         end
         total++; if ((own_exp ? m0_if.rdata : m1_if.rdata) !== 32'h0) begin bad++; $display("FAIL rnd_idle_rdata t=%0d exp=00000000", t); end
         total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rnd_timeout t=%0d got=%b exp=0", t, timeout); end
         if (exp_sb) begin
            total++; if (s_if.addr !== c_addr || s_if.wdata !== c_wdata || s_if.ttype !== c_tt || s_if.tsize !== c_ts) begin
               bad++; $display("FAIL rnd_fwd t=%0d got addr=%h wd=%h tt=%0d ts=%0d exp addr=%h wd=%h tt=%0d ts=%0d",
                               t, s_if.addr, s_if.wdata, s_if.ttype, s_if.tsize, c_addr, c_wdata, c_tt, c_ts);
            end
         end
         if (exp_done) begin
            total++; if ((srv_own ? m1_if.rdata : m0_if.rdata) !== rd) begin bad++; $display("FAIL rnd_rdata t=%0d exp=%h", t, rd); end
            serving   = 1'b0;
            outst[srv_own] = 1'b0;
            ready_cyc = t + 1;
         end
         if (!serving && t >= ready_cyc && (wait_v[0] || wait_v[1])) begin
            if (wait_v[0] && wait_v[1]) w = dbg_prio ? 1 : int'(pref);
            else                        w = wait_v[1] ? 1 : 0;
            serving   = 1'b1;
            srv_own   = (w == 1);
            own_exp   = srv_own;
            pref      = ~srv_own;
            wait_v[w] = 1'b0;
            c_tt = w_tt[w]; c_ts = w_ts[w]; c_addr = w_addr[w]; c_wdata = w_wdata[w];
            start_cyc = t + 1;
            done_cyc  = start_cyc + int'($urandom_range(0, 3));
         end
      end
      dbg_prio = 1'b0;
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      init_inputs();
      test_reset();
      test_single_read();
      test_same_cycle();
      test_fairness();
      test_write_during_wait();
      test_done_collision();
      test_reset_in_wait();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
